// File: rtl/exec_pkg.sv
// Shared types and constants for the execution-stage sequencing controller.
package exec_pkg;

  typedef enum logic [1:0] {
    CLS_INT   = 2'b00,
    CLS_FIXED = 2'b01,
    CLS_VEC   = 2'b10,
    CLS_ILL   = 2'b11
  } cls_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  localparam logic [4:0] OP_NOP = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HOLD
  } state_e;

  function automatic logic is_illegal(input logic [4:0] opc);
    return (opc[4:3] == CLS_ILL) ||
           !((opc[2:0] == OP_ADD) || (opc[2:0] == OP_SUB) || (opc[2:0] == OP_MUL));
  endfunction

endpackage

// File: rtl/exec_fwd_unit.sv
// Forwarding tracker: remembers {valid, rd, class} of the last retired writing
// instruction and compares incoming sources against it, bypassing a same-edge retire.
module exec_fwd_unit
  import exec_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_i,
  input  logic [REG_ADDR_W-1:0] upd_rd_i,
  input  cls_e                  upd_cls_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  cls_e                  cls_i,
  output logic                  sel_a_o,
  output logic                  sel_b_o
);

  logic                  trk_vld_q;
  logic [REG_ADDR_W-1:0] trk_rd_q;
  cls_e                  trk_cls_q;

  logic                  vld_eff;
  logic [REG_ADDR_W-1:0] rd_eff;
  cls_e                  cls_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_vld_q <= 1'b0;
      trk_rd_q  <= '0;
      trk_cls_q <= CLS_INT;
    end else if (upd_i) begin
      trk_vld_q <= 1'b1;
      trk_rd_q  <= upd_rd_i;
      trk_cls_q <= upd_cls_i;
    end
  end

  // A retire on this edge must be visible to an instruction accepted on it.
  always_comb begin
    vld_eff = trk_vld_q;
    rd_eff  = trk_rd_q;
    cls_eff = trk_cls_q;
    if (upd_i) begin
      vld_eff = 1'b1;
      rd_eff  = upd_rd_i;
      cls_eff = upd_cls_i;
    end
  end

  assign sel_a_o = vld_eff && (rs1_i == rd_eff) && (cls_i == cls_eff);
  assign sel_b_o = vld_eff && (rs2_i == rd_eff) && (cls_i == cls_eff);

endmodule

// File: rtl/exec_ctrl.sv
// Execution-stage sequencer: one instruction in flight, MUL latency counter, N/V/Z capture.
// Forwarding selects are built only when EXEC_CTRL_FWD_EN is defined; otherwise they stay 0.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int REG_ADDR_W  = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_wb_en,
  output logic [4:0]            ex_opcode,
  output logic                  s_mux_A,
  output logic                  s_mux_B,
  input  logic [2:0]            alu_nvz_int,
  input  logic [2:0]            alu_nvz_fixed,
  input  logic [2:0]            alu_nvz_vec_any,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wb_en,
  output logic [1:0]            out_class,
  output logic [2:0]            flags,
  output logic                  illegal
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);

  if (DATA_WIDTH < 1 || MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_param_chk
    $error("exec_ctrl: unsupported parameter values");
  end

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [4:0]            ex_opcode_q, ex_opcode_d;
  logic                  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_wb_en_q, out_wb_en_d;
  logic [1:0]            out_class_q, out_class_d;
  logic [2:0]            flags_q, flags_d;
  logic [2:0]            nvz_q, nvz_d;
  logic                  illegal_q, illegal_d;
  logic                  ill_q, ill_d;

  logic       accept, retire, in_ill, in_mul, fwd_a, fwd_b;
  logic [2:0] nvz_sel;

  assign out_valid = ((state_q == S_EXEC) && (cnt_q == 4'd0)) || (state_q == S_HOLD);
  assign retire    = out_valid && out_ready;
  assign in_ready  = (state_q == S_IDLE) || retire;
  assign accept    = in_valid && in_ready;
  assign in_ill    = is_illegal(in_opcode);
  assign in_mul    = !in_ill && (in_opcode[2:0] == OP_MUL);

  always_comb begin
    case (cls_e'(out_class_q))
      CLS_INT:   nvz_sel = alu_nvz_int;
      CLS_FIXED: nvz_sel = alu_nvz_fixed;
      CLS_VEC:   nvz_sel = alu_nvz_vec_any;
      default:   nvz_sel = 3'b000;
    endcase
  end

`ifdef EXEC_CTRL_FWD_EN
  exec_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .clk       (clk),
    .rst       (rst),
    .upd_i     (retire && out_wb_en_q),
    .upd_rd_i  (out_rd_q),
    .upd_cls_i (cls_e'(out_class_q)),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .cls_i     (cls_e'(in_opcode[4:3])),
    .sel_a_o   (fwd_a),
    .sel_b_o   (fwd_b)
  );
`else
  logic unused_rs;
  assign unused_rs = ^{in_rs1, in_rs2};
  assign fwd_a     = 1'b0;
  assign fwd_b     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_opcode_d = ex_opcode_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    out_rd_d    = out_rd_q;
    out_wb_en_d = out_wb_en_q;
    out_class_d = out_class_q;
    flags_d     = flags_q;
    nvz_d       = nvz_q;
    illegal_d   = 1'b0;
    ill_d       = ill_q;

    if (state_q == S_EXEC) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else if (!out_ready) begin
        state_d = S_HOLD;
        nvz_d   = nvz_sel;
      end
    end

    // Flags come from the completion-cycle sample, even after a HOLD stretch.
    if (retire) begin
      if (!ill_q) flags_d = (state_q == S_HOLD) ? nvz_q : nvz_sel;
      state_d     = S_IDLE;
      ex_opcode_d = OP_NOP;
      sel_a_d     = 1'b0;
      sel_b_d     = 1'b0;
    end

    if (accept) begin
      state_d     = S_EXEC;
      cnt_d       = in_mul ? MUL_CNT : 4'd0;
      ex_opcode_d = in_ill ? OP_NOP : in_opcode;
      sel_a_d     = fwd_a;
      sel_b_d     = fwd_b;
      out_rd_d    = in_rd;
      out_wb_en_d = in_wb_en && !in_ill;
      out_class_d = in_opcode[4:3];
      illegal_d   = in_ill;
      ill_d       = in_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ex_opcode_q <= OP_NOP;
      sel_a_q     <= 1'b0;
      sel_b_q     <= 1'b0;
      out_rd_q    <= '0;
      out_wb_en_q <= 1'b0;
      out_class_q <= 2'b00;
      flags_q     <= 3'b000;
      nvz_q       <= 3'b000;
      illegal_q   <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_opcode_q <= ex_opcode_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      out_rd_q    <= out_rd_d;
      out_wb_en_q <= out_wb_en_d;
      out_class_q <= out_class_d;
      flags_q     <= flags_d;
      nvz_q       <= nvz_d;
      illegal_q   <= illegal_d;
      ill_q       <= ill_d;
    end
  end

  assign ex_opcode = ex_opcode_q;
  assign s_mux_A   = sel_a_q;
  assign s_mux_B   = sel_b_q;
  assign out_rd    = out_rd_q;
  assign out_wb_en = out_wb_en_q;
  assign out_class = out_class_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed vector table, multi-cycle corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_exec_ctrl;

  localparam int         LAT = 3;
  localparam logic [4:0] NOP = 5'b11111;
`ifdef EXEC_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_wb_en, s_mux_A, s_mux_B;
  logic [4:0] in_opcode, ex_opcode;
  logic [3:0] in_rd, in_rs1, in_rs2, out_rd;
  logic [2:0] alu_nvz_int, alu_nvz_fixed, alu_nvz_vec_any, flags;
  logic       out_valid, out_ready, out_wb_en, illegal;
  logic [1:0] out_class;

  int n_checks = 0;
  int n_errors = 0;

  exec_ctrl #(.DATA_WIDTH(16), .REG_ADDR_W(4), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_wb_en(in_wb_en), .ex_opcode(ex_opcode), .s_mux_A(s_mux_A), .s_mux_B(s_mux_B),
    .alu_nvz_int(alu_nvz_int), .alu_nvz_fixed(alu_nvz_fixed),
    .alu_nvz_vec_any(alu_nvz_vec_any), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_class(out_class), .flags(flags),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Selected class gets the wanted flags; the others get the inverse so a wrong pick shows.
  task automatic set_alu(input logic [1:0] cls, input logic [2:0] nvz);
    alu_nvz_int     = (cls == 2'b00) ? nvz : ~nvz;
    alu_nvz_fixed   = (cls == 2'b01) ? nvz : ~nvz;
    alu_nvz_vec_any = (cls == 2'b10) ? nvz : ~nvz;
  endtask

  function automatic logic [2:0] pick(input logic [1:0] cls);
    case (cls)
      2'b00:   return alu_nvz_int;
      2'b01:   return alu_nvz_fixed;
      2'b10:   return alu_nvz_vec_any;
      default: return 3'b000;
    endcase
  endfunction

  // Present an instruction for one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic wb);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_wb_en = wb;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0] op;
    logic [3:0] rd;
    logic       wb;
    logic [2:0] nvz;
    int         lat;
    logic [4:0] exp_ex;
    logic       exp_ill;
    logic       exp_wb;
    logic [2:0] exp_flags;
  } vec_t;

  vec_t tbl[7];

  // Reference model state
  bit         m_have, m_sampled, m_ill, m_wb, m_sa, m_sb, m_illp, m_trk_v;
  logic [4:0] m_op;
  logic [3:0] m_rd, m_trk_rd;
  logic [1:0] m_cls, m_trk_cls;
  logic [2:0] m_flags, m_sample;
  int         m_wait;

  initial begin
    int  lat;
    bit  exp_ov, exp_ir;

    tbl[0] = '{5'b00000, 4'd3,  1'b1, 3'b001, 1,   5'b00000, 1'b0, 1'b1, 3'b001};
    tbl[1] = '{5'b01001, 4'd7,  1'b1, 3'b100, 1,   5'b01001, 1'b0, 1'b1, 3'b100};
    tbl[2] = '{5'b10010, 4'd9,  1'b1, 3'b010, LAT, 5'b10010, 1'b0, 1'b1, 3'b010};
    tbl[3] = '{5'b11010, 4'd2,  1'b1, 3'b111, 1,   NOP,      1'b1, 1'b0, 3'b010};
    tbl[4] = '{5'b00111, 4'd1,  1'b1, 3'b101, 1,   NOP,      1'b1, 1'b0, 3'b010};
    tbl[5] = '{5'b00010, 4'd4,  1'b0, 3'b110, LAT, 5'b00010, 1'b0, 1'b0, 3'b110};
    tbl[6] = '{5'b10000, 4'd15, 1'b1, 3'b011, 1,   5'b10000, 1'b0, 1'b1, 3'b011};

    rst = 1'b1; in_valid = 1'b0; in_opcode = 5'b0; in_rd = 4'd0; in_rs1 = 4'd0;
    in_rs2 = 4'd0; in_wb_en = 1'b0; out_ready = 1'b1; set_alu(2'b00, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ex_opcode", ex_opcode, NOP);
    chk("rst_s_mux_A", s_mux_A, 1'b0);
    chk("rst_s_mux_B", s_mux_B, 1'b0);
    chk("rst_out_rd", out_rd, 4'd0);
    chk("rst_out_wb_en", out_wb_en, 1'b0);
    chk("rst_out_class", out_class, 2'b00);
    chk("rst_flags", flags, 3'b000);
    chk("rst_illegal", illegal, 1'b0);

    // Directed single-instruction vectors, out_ready held high
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_opcode = tbl[i].op; in_rd = tbl[i].rd; in_rs1 = 4'd0;
      in_rs2 = 4'd0; in_wb_en = tbl[i].wb; out_ready = 1'b1;
      set_alu(tbl[i].op[4:3], tbl[i].nvz);
      #1 chk("vec_in_ready", in_ready, 1'b1);
      @(posedge clk);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (c == 1) chk("vec_illegal_pulse", illegal, tbl[i].exp_ill);
        if (out_valid) begin
          lat = c;
          chk("vec_ex_opcode", ex_opcode, tbl[i].exp_ex);
          chk("vec_out_rd", out_rd, tbl[i].rd);
          chk("vec_out_wb_en", out_wb_en, tbl[i].exp_wb);
          chk("vec_out_class", out_class, tbl[i].op[4:3]);
        end
      end
      chk("vec_latency", lat, tbl[i].lat);
      @(negedge clk);
      #1;
      chk("vec_flags", flags, tbl[i].exp_flags);
      chk("vec_idle_valid", out_valid, 1'b0);
      chk("vec_idle_opcode", ex_opcode, NOP);
      chk("vec_idle_illegal", illegal, 1'b0);
    end

    // Vector MUL under backpressure; flags must be the completion-cycle sample
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 5'b10010; in_rd = 4'd6; in_wb_en = 1'b1; out_ready = 1'b0;
    set_alu(2'b10, 3'b101);
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c >= 4) set_alu(2'b10, 3'b000);
      if (c == 6) out_ready = 1'b1;
      #1;
      chk("bp_out_valid", out_valid, c >= 3);
      chk("bp_in_ready", in_ready, c == 6);
      chk("bp_ex_opcode", ex_opcode, 5'b10010);
    end
    @(negedge clk);
    #1;
    chk("bp_flags", flags, 3'b101);
    chk("bp_done", out_valid, 1'b0);

    // Same-edge forwarding: same class, then fixed class
    for (int k = 0; k < 2; k++) begin
      issue(5'b00000, 4'd5, 4'd0, 4'd0, 1'b1);
      in_valid = 1'b1; in_opcode = (k == 0) ? 5'b00001 : 5'b01001;
      in_rd = 4'd8; in_rs1 = 4'd5; in_rs2 = 4'd2; in_wb_en = 1'b1;
      #1;
      chk("fwd_retire_valid", out_valid, 1'b1);
      chk("fwd_in_ready", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("fwd_s_mux_A", s_mux_A, (k == 0) ? FWD : 1'b0);
      chk("fwd_s_mux_B", s_mux_B, 1'b0);
      chk("fwd_ex_opcode", ex_opcode, (k == 0) ? 5'b00001 : 5'b01001);
      @(negedge clk);
    end

    // Reset in the first cycle of a MUL: it must vanish and the tracker with it
    issue(5'b00000, 4'd5, 4'd0, 4'd0, 1'b1);
    issue(5'b00010, 4'd5, 4'd0, 4'd0, 1'b1);
    rst = 1'b1;
    #1 chk("rmul_valid_in_rst", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("rmul_no_valid", out_valid, 1'b0);
      chk("rmul_in_ready", in_ready, 1'b1);
      chk("rmul_opcode", ex_opcode, NOP);
      chk("rmul_flags", flags, 3'b000);
    end
    set_alu(2'b00, 3'b001);
    issue(5'b00000, 4'd9, 4'd5, 4'd5, 1'b1);
    #1;
    chk("rmul_add_valid", out_valid, 1'b1);
    chk("rmul_sel_a", s_mux_A, 1'b0);
    chk("rmul_sel_b", s_mux_B, 1'b0);
    @(negedge clk);
    #1 chk("rmul_add_flags", flags, 3'b001);

    // Randomized run against the transaction-level model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_have = 0; m_sampled = 0; m_illp = 0; m_trk_v = 0; m_flags = 3'b000;
    m_trk_rd = 4'd0; m_trk_cls = 2'b00; m_wait = 0; m_ill = 0; m_wb = 0;
    m_sa = 0; m_sb = 0; m_op = NOP; m_rd = 4'd0; m_cls = 2'b00; m_sample = 3'b000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_opcode = ($urandom_range(0, 9) < 8)
                  ? {2'($urandom_range(0, 2)), 3'($urandom_range(0, 2))} : 5'($urandom);
      in_rd     = 4'($urandom_range(0, 3));
      in_rs1    = 4'($urandom_range(0, 3));
      in_rs2    = 4'($urandom_range(0, 3));
      in_wb_en  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_nvz_int = 3'($urandom); alu_nvz_fixed = 3'($urandom); alu_nvz_vec_any = 3'($urandom);
      #1;
      exp_ov = m_have && (m_wait == 0);
      exp_ir = !m_have || (exp_ov && out_ready);
      chk("rnd_out_valid", out_valid, exp_ov);
      chk("rnd_in_ready", in_ready, exp_ir);
      chk("rnd_ex_opcode", ex_opcode, (m_have && !m_ill) ? m_op : NOP);
      chk("rnd_s_mux_A", s_mux_A, m_have && m_sa);
      chk("rnd_s_mux_B", s_mux_B, m_have && m_sb);
      chk("rnd_flags", flags, m_flags);
      chk("rnd_illegal", illegal, m_illp);
      if (exp_ov) begin
        chk("rnd_out_rd", out_rd, m_rd);
        chk("rnd_out_wb_en", out_wb_en, m_wb);
        chk("rnd_out_class", out_class, m_cls);
      end
      if (exp_ov && !m_sampled) begin
        m_sample  = pick(m_cls);
        m_sampled = 1;
      end
      if (exp_ov && out_ready) begin
        if (!m_ill) m_flags = m_sample;
        if (m_wb) begin
          m_trk_v = 1; m_trk_rd = m_rd; m_trk_cls = m_cls;
        end
        m_have = 0;
      end else if (m_have && m_wait > 0) begin
        m_wait--;
      end
      m_illp = 0;
      if (in_valid && exp_ir) begin
        m_ill     = (in_opcode[4:3] == 2'b11) || (in_opcode[2:0] > 3'd2);
        m_op      = in_opcode;
        m_rd      = in_rd;
        m_wb      = in_wb_en && !m_ill;
        m_cls     = in_opcode[4:3];
        m_sa      = FWD && m_trk_v && (in_rs1 == m_trk_rd) && (in_opcode[4:3] == m_trk_cls);
        m_sb      = FWD && m_trk_v && (in_rs2 == m_trk_rd) && (in_opcode[4:3] == m_trk_cls);
        m_wait    = (!m_ill && in_opcode[2:0] == 3'd2) ? LAT - 1 : 0;
        m_have    = 1;
        m_sampled = 0;
        m_illp    = m_ill;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
